// File: rtl/clock_n_divider.sv
// Integer clock divider: free-running registered square wave with period DIVIDER
// input clocks, high for ceil(N/2) cycles and low for the remainder.
module clock_n_divider #(
  parameter int unsigned DIVIDER = 25
) (
  input  logic INPUT_CLK,
  input  logic RST,
  output logic OUTPUT_CLK
);

  localparam int unsigned HIGH   = (DIVIDER + 1) / 2;
  localparam int unsigned CLOG_N = $clog2(DIVIDER);
  localparam int unsigned CW     = (CLOG_N < 1) ? 1 : CLOG_N;

  if ((DIVIDER < 2) || (DIVIDER > 65536)) begin : g_bad_divider
    $error("clock_n_divider: DIVIDER must be in 2..65536");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  // Output level is decided from the count the edge is about to load.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    out_d = 1'b0;
    if (cnt_q == CW'(DIVIDER - 1)) begin
      cnt_d = '0;
    end
    if ((cnt_d != '0) && (cnt_d <= CW'(HIGH))) begin
      out_d = 1'b1;
    end
  end

  always_ff @(posedge INPUT_CLK) begin
    if (RST) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign OUTPUT_CLK = out_q;

endmodule

// File: tb/tb_clock_n_divider.sv
// Scoreboard bench for clock_n_divider: three instances (N=25, 4, 2) checked
// every edge against an edge-count reference model, plus N=25 waveform stats.
`timescale 1ns/1ps
module tb_clock_n_divider;

  localparam int unsigned N0 = 25;
  localparam int unsigned N1 = 4;
  localparam int unsigned N2 = 2;

  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  logic o0, o1, o2;

  always #1500 clk = ~clk;

  clock_n_divider #(.DIVIDER(N0)) u_div25 (.INPUT_CLK(clk), .RST(rst0), .OUTPUT_CLK(o0));
  clock_n_divider #(.DIVIDER(N1)) u_div4  (.INPUT_CLK(clk), .RST(rst1), .OUTPUT_CLK(o1));
  clock_n_divider #(.DIVIDER(N2)) u_div2  (.INPUT_CLK(clk), .RST(rst2), .OUTPUT_CLK(o2));

  bit q0[$];
  bit q1[$];
  bit q2[$];
  int k0, k1, k2;
  int checks = 0;
  int errors = 0;

  // Edge k after reset release: output high iff (k mod n) lies in 1..ceil(n/2).
  function automatic bit ref_level(input int k, input int n);
    int h;
    int m;
    h = (n + 1) / 2;
    m = k % n;
    return (m >= 1) && (m <= h);
  endfunction

  task automatic drive(input bit r0, input bit r1, input bit r2);
    rst0 = r0;
    rst1 = r1;
    rst2 = r2;
    if (r0) begin k0 = 0; q0.push_back(1'b0); end
    else begin k0++; q0.push_back(ref_level(k0, N0)); end
    if (r1) begin k1 = 0; q1.push_back(1'b0); end
    else begin k1++; q1.push_back(ref_level(k1, N1)); end
    if (r2) begin k2 = 0; q2.push_back(1'b0); end
    else begin k2++; q2.push_back(ref_level(k2, N2)); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmp(input string nm, input int edge_no, input logic act, input bit have, input bit exp);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s edge %0d: output seen but no expectation queued", nm, edge_no);
    end else if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %b expected %b", nm, edge_no, act, exp);
    end
  endtask

  // Monitor: one sample per rising edge, popped against the scoreboard queues.
  int  s = 0;
  logic prev0 = 1'b0;
  int  rises = 0, falls = 0, run_len = 0;
  bit  run_ok = 1'b0;
  bit  e;
  bit  have;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      s++;
      have = (q0.size() != 0); e = have ? q0.pop_front() : 1'b0;
      cmp("out_n25", s, o0, have, e);
      have = (q1.size() != 0); e = have ? q1.pop_front() : 1'b0;
      cmp("out_n4", s, o1, have, e);
      have = (q2.size() != 0); e = have ? q2.pop_front() : 1'b0;
      cmp("out_n2", s, o2, have, e);

      // Waveform statistics over the 750 edges following the first release.
      if (s >= 4 && s <= 753) begin
        if (o0 !== prev0) begin
          if (o0 === 1'b1) rises++; else falls++;
          if (run_ok) begin
            checks++;
            if (run_len != (prev0 ? 13 : 12)) begin
              errors++;
              $display("FAIL phase_len_n25 edge %0d: level %b lasted %0d cycles, expected %0d",
                       s, prev0, run_len, prev0 ? 13 : 12);
            end
          end
          run_ok  = 1'b1;
          run_len = 1;
        end else begin
          run_len++;
        end
      end
      if (s == 753) begin
        checks++;
        if (rises != 30) begin
          errors++;
          $display("FAIL rise_count_n25: got %0d expected 30", rises);
        end
        checks++;
        if (falls != 30) begin
          errors++;
          $display("FAIL fall_count_n25: got %0d expected 30", falls);
        end
      end
      prev0 = o0;
    end
  end

  initial begin
    k0 = 0; k1 = 0; k2 = 0;
    repeat (3)  drive(1'b1, 1'b1, 1'b1);
    repeat (750) drive(1'b0, 1'b0, 1'b0);
    // Mid-period reset on the 7th edge of a fresh N=25 period (output high).
    repeat (6)  drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (30) drive(1'b0, 1'b0, 1'b0);
    repeat (50) drive(1'b1, 1'b1, 1'b1);
    repeat (40) drive(1'b0, 1'b0, 1'b0);
    repeat (2000) drive($urandom_range(39) == 0, $urandom_range(39) == 0, $urandom_range(39) == 0);
    #100;
    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
